// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : audio_pkg
//  Purpose  : Shared types and step-decode masks for the PSG frame sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package audio_pkg;

    typedef logic [2:0] seq_step_t;

    // Bit n set means the tick fires when leaving step n.
    localparam logic [7:0] LEN_STEP_MASK   = 8'b0101_0101;
    localparam logic [7:0] SWEEP_STEP_MASK = 8'b0100_0100;
    localparam logic [7:0] ENV_STEP_MASK   = 8'b1000_0000;

    function automatic logic step_in_mask(input logic [7:0] mask, input seq_step_t s);
        return mask[s];
    endfunction

endpackage
`default_nettype wire

// File: rtl/audio_step_divider.sv
`default_nettype none
// ============================================================================
//  Module   : audio_step_divider
//  Purpose  : Step-rate divider; pulses o_term on the last count of each step.
//  Revision : 1.0  initial release
// ============================================================================
module audio_step_divider #(
    parameter int STEP_DIV = 195312,
    parameter int CNT_W    = 18
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_term
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == c_last);
    assign o_term    = i_en & ~i_clr & w_at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_en || i_clr || w_at_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/audio_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : audio_frame_sequencer
//  Purpose  : 512 Hz frame sequencer producing length/sweep/envelope ticks and
//             per-channel restart pulses from the level-type trigger bits.
//  Revision : 1.0  initial release
// ============================================================================
module audio_frame_sequencer
    import audio_pkg::*;
#(
    parameter int STEP_DIV = 195312,
    parameter int CNT_W    = 18
) (
    input  logic       clk_100,
    input  logic       reset_n,
    input  logic       master_en,
    input  logic       seq_rst,
    input  logic [3:0] ch_trig,
    output logic [2:0] step,
    output logic       step_strobe,
    output logic       length_tick,
    output logic       sweep_tick,
    output logic       env_tick,
    output logic [3:0] ch_restart
);

    seq_step_t   r_step;
    logic        r_strobe;
    logic        r_len;
    logic        r_sweep;
    logic        r_env;
    logic [3:0]  r_trig_q;
    logic [3:0]  r_restart;
    logic        w_term;
    logic [3:0]  w_rise;

    audio_step_divider #(
        .STEP_DIV (STEP_DIV),
        .CNT_W    (CNT_W)
    ) u_div (
        .clk    (clk_100),
        .rst_n  (reset_n),
        .i_en   (master_en),
        .i_clr  (seq_rst),
        .o_term (w_term)
    );

    assign w_rise = ch_trig & ~r_trig_q;

    // Trigger history keeps sampling while disabled so a held trigger never fires on enable.
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            r_trig_q  <= '0;
            r_restart <= '0;
        end else begin
            r_trig_q  <= ch_trig;
            r_restart <= w_rise & {4{master_en}};
        end
    end

    // Tick decodes look at the step being left, before it advances.
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            r_step   <= '0;
            r_strobe <= 1'b0;
            r_len    <= 1'b0;
            r_sweep  <= 1'b0;
            r_env    <= 1'b0;
        end else if (!master_en || seq_rst) begin
            r_step   <= '0;
            r_strobe <= 1'b0;
            r_len    <= 1'b0;
            r_sweep  <= 1'b0;
            r_env    <= 1'b0;
        end else begin
            r_strobe <= w_term;
            r_len    <= w_term & step_in_mask(LEN_STEP_MASK, r_step);
            r_sweep  <= w_term & step_in_mask(SWEEP_STEP_MASK, r_step);
            r_env    <= w_term & step_in_mask(ENV_STEP_MASK, r_step);
            if (w_term) begin
                r_step <= seq_step_t'(r_step + 1'b1);
            end
        end
    end

    assign step        = r_step;
    assign step_strobe = r_strobe;
    assign length_tick = r_len;
    assign sweep_tick  = r_sweep;
    assign env_tick    = r_env;
    assign ch_restart  = r_restart;

endmodule
`default_nettype wire
